seg_scan_driver: RTL
====================

# seg_scan_driver

Time-multiplexed, parametrised seven-segment display driver. It latches a packed hex word, per-digit decimal points and a per-digit blank mask, then scans the digits one at a time through registered segment and digit-enable outputs. A dead cycle at every digit change suppresses ghosting. It sits between the CPU's memory-mapped display register and the board's segment/anode pins, and replaces the bare combinational hex-to-segment lookup.

## Interface
- DIGITS, 8, number of digits scanned (1..16)
- CLK_HZ, 100_000_000, input clock frequency
- SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit, DIV ≥ 2 (elaboration error otherwise)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  single-cycle strobe: capture data_in/dp_in/blank_in
- data_in  in  4*DIGITS  packed nibbles, digit i = data_in[4i+3:4i], digit 0 rightmost
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- blank_in  in  DIGITS  1 = digit dark regardless of data
- seg_out  out  8  segments, active high, bit7=a … bit1=g, bit0=dp
- an_out  out  DIGITS  digit enable, active high, at most one bit set
- frame_start  out  1  one-cycle pulse when digit 0 begins a new scan

## Operation
- Shadow registers data_q/dp_q/blank_q are loaded on the cycle after load=1. All-zero on reset. load is accepted any cycle. The displayed digit switches to the new value at its next dead cycle, never mid-dwell.
- Dwell counter cnt runs 0..DIV-1. At cnt==DIV-1 it wraps to 0 and digit index idx advances (DIGITS-1 → 0).
- Hex decode is fixed, upper 7 bits: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 F6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E. seg_out[0] = dp_q[idx].
- A blanked digit drives seg_out = 00. Its anode still follows the scan, so the duty cycle stays uniform.

## Timing
- Reset values: cnt=0, idx=0, seg_out=00, an_out=0, frame_start=0, shadows=0.
- Outputs are registered and are driven from idx/cnt after the clock edge.
- Cycle with cnt==0 (dead cycle): an_out=0. seg_out takes the decode of digit idx.
- Cycles with cnt in 1..DIV-1: an_out=one-hot(idx) and seg_out is held.
- frame_start=1 exactly on the dead cycle where idx==0.
- Full frame = DIGITS*DIV cycles.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronous). After rst_n rises, the first cycle is the dead cycle of digit 0 with frame_start=1.
- load coincident with a dead cycle: the old shadow value is shown for that dwell. The new value appears from the following digit's dead cycle.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: leading zeros are blanked.
  - The scan runs from digit DIGITS-1 downward.
  - Digit i is blanked while data_q nibble is 0, dp_q[i]=0, and every higher digit is also blanked by this rule.
  - Digit 0 is never blanked by this rule.
  - The resulting mask is recomputed combinationally from the shadows.
- Undefined: only blank_in blanks.

## Structure
- Package seg_pkg holds:
  - segment bit-position constants (SEG_A..SEG_G, SEG_DP)
  - the 16-entry hex glyph constant array
  - SEG_OFF = 8'h00
- Sub-module hex_to_seg: combinational 4-bit nibble + dp to 8-bit seg, built on the seg_pkg glyph table.
- Top holds the dwell counter, scan index, shadows, optional leading-zero mask and output registers.

## Test plan
All scenarios use DIGITS=4, CLK_HZ=1000, SCAN_HZ=250, giving DIV=4.
- Reset release with shadows 0:
  - cycle 1 → an_out=0000, frame_start=1
  - cycles 2–4 → an_out=0001, seg_out=FC
  - then digit 1 dead cycle
- load data_in=16'h12AF, dp_in=0010, blank_in=0 → over one frame, seg per digit 0..3 = 8E, EF (A+dp), DA, 60. an_out is one-hot and 0 on every dead cycle.
- blank_in=0100 → digit 2 shows seg_out=00 while an_out=0100 still asserts for 3 cycles.
- load asserted on digit 1's dead cycle → digit 1 shows the old value. Digit 2 onward shows the new value.
- rst_n pulsed low mid-dwell of digit 2:
  - outputs are 0 asynchronously
  - shadows clear
  - scan restarts at digit 0 with frame_start
- With SEG_LEADING_ZERO_BLANK_EN defined:
  - data_in=16'h0050 → digits 3,2 blanked; digits 1,0 show B6, FC
  - data_in=0 → only digit 0 lit (FC)

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and the all-off pattern.
package seg_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Segments a..g occupy bits 7..1; bit 0 (dp) is always clear in the table.
  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble + decimal-point to active-high segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = HEX_GLYPH[nibble] | (8'(dp) << SEG_DP);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with a dead cycle per digit.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS  = 8,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (DIV < 2 || DIGITS < 1 || DIGITS > 16) begin : g_bad_cfg
      $error("seg_scan_driver: need CLK_HZ/SCAN_HZ >= 2 and 1 <= DIGITS <= 16");
    end
  endgenerate

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [DIGITS-1:0]     blank_q;
  logic [DIGITS-1:0]     blank_eff;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic [7:0]            cur_seg;
  logic                  cnt_last;
  logic                  idx_last;
  logic                  dead;

  assign cnt_last = (cnt == CW'(DIV - 1));
  assign idx_last = (idx == IW'(DIGITS - 1));
  assign dead     = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadows are plain flops, not a memory, so clearing them on reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (load) begin
      data_q  <= data_in;
      dp_q    <= dp_in;
      blank_q <= blank_in;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit stays in the blank run
  // only while it and every digit above it is a zero with no decimal point.
  logic [DIGITS-1:0] lz_mask;
  logic              run;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lz_mask = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run && (data_q[4*i +: 4] == 4'h0) && !dp_q[i];
      lz_mask[i] = run;
    end
  end

  assign blank_eff = blank_q | lz_mask;
`else
  assign blank_eff = blank_q;
`endif

  assign cur_nibble = data_q[4*idx +: 4];
  assign cur_dp     = dp_q[idx];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (cur_seg)
  );

  // The dead cycle fetches the new glyph with every anode off; the dwell
  // cycles then light the digit with that glyph held steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out     <= SEG_OFF;
      an_out      <= '0;
      frame_start <= 1'b0;
    end else if (dead) begin
      seg_out     <= blank_eff[idx] ? SEG_OFF : cur_seg;
      an_out      <= '0;
      frame_start <= (idx == '0);
    end else begin
      an_out      <= DIGITS'(1) << idx;
      frame_start <= 1'b0;
    end
  end

endmodule
